// File: rtl/fetch_stage_pipelined.sv
// Instruction-fetch stage: PC, writable instruction memory and a registered
// IF/ID output with valid/ready handshake, redirect/flush, program load and fault.
module fetch_stage_pipelined #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter int unsigned           PC_STEP    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         load,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] imem_waddr,
  input  logic [DATA_WIDTH-1:0]        imem_wdata,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        instruction,
  output logic [ADDR_WIDTH-1:0]        pc_current,
  output logic [ADDR_WIDTH-1:0]        pc_next,
  output logic                         fault
);

  localparam int unsigned           IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_cur_q, pc_cur_d;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valid_q, valid_d;
  logic                  fault_q, fault_d;

  logic [ADDR_WIDTH-1:0] pc_word;
  logic                  in_range;
  logic                  adv;
  logic                  redirect_aligned;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    pc_word          = pc_q / STEP;
    in_range         = pc_word < DEPTH;
    rd_data          = mem_q[pc_word[IDX_W-1:0]];
    adv              = en && !load && !fault_q && (!valid_q || out_ready);
    redirect_aligned = (redirect_pc % STEP) == '0;
  end

  always_comb begin
    pc_d      = pc_q;
    pc_cur_d  = pc_cur_q;
    pc_next_d = pc_next_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    if (load) begin
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (redirect_valid) begin
      // Flush discards the held output even if decode is accepting it this cycle.
      valid_d = 1'b0;
      if (redirect_aligned) pc_d = redirect_pc;
      else                  fault_d = 1'b1;
    end else if (adv) begin
      if (!in_range) begin
        valid_d = 1'b0;
        fault_d = 1'b1;
      end else begin
        instr_d   = rd_data;
        pc_cur_d  = pc_q;
        pc_next_d = pc_q + STEP;
        valid_d   = 1'b1;
        pc_d      = pc_q + STEP;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pc_cur_q  <= '0;
      pc_next_q <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc_cur_q  <= pc_cur_d;
      pc_next_q <= pc_next_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load && imem_we) mem_q[imem_waddr] <= imem_wdata;
  end

  assign out_valid   = valid_q;
  assign instruction = instr_q;
  assign pc_current  = pc_cur_q;
  assign pc_next     = pc_next_q;
  assign fault       = fault_q;

endmodule

// File: doc/fetch_stage_pipelined.md
Name: fetch_stage_pipelined

Overview:
Parametrised instruction-fetch stage with a registered IF/ID output. It holds the program counter and a writable instruction memory, and presents each fetched instruction with its PC and sequential next-PC over a valid/ready handshake. It adds four things to the basic fetch path: back-pressure, branch/jump redirect with flush, a program-load mode, and fault detection. It sits at the front of the execution cycle and feeds the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC and byte addresses
DATA_WIDTH, 32, instruction width
MEM_DEPTH, 256, instruction memory depth in words; power of two, at least 2
PC_STEP, 4, byte increment per sequential fetch; equals DATA_WIDTH/8
RESET_PC, 0, PC value after reset or load; must be PC_STEP-aligned

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-high reset
en  input  1  fetch enable
load  input  1  program-load mode; suspends fetching
imem_we  input  1  instruction memory write strobe, honoured only while load=1
imem_waddr  input  log2(MEM_DEPTH)  word write index
imem_wdata  input  DATA_WIDTH  write data
redirect_valid  input  1  take redirect_pc this cycle
redirect_pc  input  ADDR_WIDTH  branch/jump target
out_ready  input  1  decode stage accepts the output
out_valid  output  1  output register holds a valid instruction
instruction  output  DATA_WIDTH  fetched instruction
pc_current  output  ADDR_WIDTH  address of instruction
pc_next  output  ADDR_WIDTH  pc_current + PC_STEP, modulo 2^ADDR_WIDTH
fault  output  1  sticky fault flag (misaligned or out-of-range fetch)

Behaviour:
- Reset (async, any time, including mid-load or mid-stall):
  - internal pc=RESET_PC; out_valid=0; instruction=0; pc_current=0; pc_next=0; fault=0.
  - Memory contents are not reset.
- Memory:
  - Word array MEM_DEPTH x DATA_WIDTH.
  - Combinational read at word index pc/PC_STEP.
  - Synchronous write on clk when load=1 and imem_we=1.
  - A write at the same edge as a read of the same word: the captured instruction is the old data.
- Advance condition: adv = en && !load && !fault && (!out_valid || out_ready).
- Priority at each edge, highest first:
  1. load=1: pc<=RESET_PC, out_valid<=0. Redirect and fetch are ignored; writes are allowed.
  2. redirect_valid=1 (load=0):
     - Flush: out_valid<=0.
     - pc<=redirect_pc, regardless of en, out_ready or a pending stall.
     - If redirect_pc is not PC_STEP-aligned, set fault instead and leave pc unchanged.
  3. adv=1:
     - Output register captures instruction=mem[pc], pc_current=pc, pc_next=pc+PC_STEP.
     - out_valid<=1; pc<=pc+PC_STEP (wraps modulo 2^ADDR_WIDTH).
  4. Otherwise, if out_valid && out_ready, out_valid<=0.
  5. Otherwise, hold all state.
- Latency: one cycle from pc holding address A with adv=1 to out_valid=1 with pc_current=A.
- Throughput: one instruction per cycle when out_ready stays high.
- Stall: while out_valid=1 and out_ready=0, instruction, pc_current and pc_next are held stable and pc does not advance.
- Out-of-range fetch: word index of pc >= MEM_DEPTH with adv=1 → no capture, out_valid<=0, fault<=1.
- fault:
  - Sticky; cleared only by reset or by load=1.
  - While set, no fetch occurs. Outputs keep their last value; a held valid output may still be consumed via out_ready.
- en=0: no new fetch. A held valid output can still be consumed.
- Redirect and out_ready in the same cycle: the output is discarded, not handed over as a valid transfer.

Test Plan:
- Reset with RESET_PC=0, mem[0..2]={0x11,0x22,0x33}, en=1, out_ready=1 → cycles 1–3 give instruction 0x11/0x22/0x33, pc_current 0/4/8, pc_next 4/8/12, out_valid=1.
- Stall: out_ready=0 for 3 cycles after the first output → instruction stays 0x11 and pc_current stays 0. After release, 0x22 follows on the next cycle with no skip or duplicate.
- Redirect to 0x20 (mem[8]=0xAB) while stalled → out_valid=0 the next cycle; the following cycle gives instruction=0xAB, pc_current=0x20.
- Misaligned redirect to 0x22 → fault=1, out_valid=0, no further fetch. Pulsing load clears fault and pc=RESET_PC.
- Load: load=1, writes 0xDEAD to word 0 and 0xBEEF to word 1, then load=0 → first outputs are 0xDEAD at pc 0 and 0xBEEF at pc 4. Assert reset mid-stream → out_valid=0 immediately, without waiting for a clock edge.
- Wrap and out-of-range: with MEM_DEPTH=4, sequential fetch reaches pc=16 → fault=1 after word 3 is delivered. Redirect to 0xFFFFFFFC with ADDR_WIDTH=32 → fault set, since the word index is out of range.
